// File: rtl/apu_pkg.sv
// Shared APU constants and types for the channel-3 wave pattern RAM.
// Holds the FF30-FF3F address map, open-bus value and the index/sample types.
package apu_pkg;

  localparam logic [15:0] WAVE_RAM_BASE         = 16'hFF30;
  localparam int          WAVE_RAM_BYTES        = 16;
  localparam logic [7:0]  OPEN_BUS_DEFAULT      = 8'hFF;
  localparam int          ACCESS_WINDOW_DEFAULT = 2;

  typedef logic [3:0] wave_idx_t;
  typedef logic [3:0] sample_t;

  function automatic logic is_wave_hit(input logic [15:0] addr);
    return addr[15:4] == WAVE_RAM_BASE[15:4];
  endfunction

endpackage

// File: rtl/wave_pattern_ram_if.sv
// Bundle of CPU bus and channel-3 fetch signals seen by the wave pattern RAM.
// master = CPU/channel-3 side, slave = the RAM responder.
interface wave_pattern_ram_if;
  import apu_pkg::*;

  logic [15:0] a;
  logic [7:0]  d_in;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        ch3_active;
  wave_idx_t   wave_a;
  logic        efar_q;
  logic        wave_fetch;
  sample_t     wave_play_d;

  modport master (
    output a, d_in, cpu_wr, cpu_rd, ch3_active, wave_a, efar_q, wave_fetch,
    input  d_out, d_oe, wave_play_d
  );

  modport slave (
    input  a, d_in, cpu_wr, cpu_rd, ch3_active, wave_a, efar_q, wave_fetch,
    output d_out, d_oe, wave_play_d
  );

endinterface

// File: rtl/wave_ram_array.sv
// 16x8 wave pattern storage: one synchronous write port, two asynchronous
// read ports (CPU path and channel-3 fetch path).
module wave_ram_array
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  wave_idx_t  waddr,
  input  logic [7:0] wdata,
  input  wave_idx_t  cpu_addr,
  output logic [7:0] cpu_q,
  input  wave_idx_t  fetch_addr,
  output logic [7:0] fetch_q
);

  logic [7:0] mem [WAVE_RAM_BYTES];

  // NOTE: the storage array has no reset; its power-on contents are undefined
  // on real hardware and a reset port would stop it mapping onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Async reads return pre-write data during a same-cycle write.
  assign cpu_q   = mem[cpu_addr];
  assign fetch_q = mem[fetch_addr];

endmodule

// File: rtl/wave_pattern_ram.sv
// Channel-3 wave pattern RAM responder: CPU decode, playback access-window
// arbitration, sample play latch and registered CPU read data.
module wave_pattern_ram
  import apu_pkg::*;
#(
  parameter int         ACCESS_WINDOW = ACCESS_WINDOW_DEFAULT,
  parameter logic [7:0] OPEN_BUS      = OPEN_BUS_DEFAULT
) (
  input  logic               clk,
  input  logic               apu_reset,
  wave_pattern_ram_if.slave  bus
);

  localparam int CW = $clog2(ACCESS_WINDOW + 2);

  logic [CW-1:0] win_cnt_q;
  logic [7:0]    latch_q;
  logic [7:0]    d_out_q;
  logic          d_oe_q;

  logic          hit;
  logic          window_open;
  logic          access_ok;
  wave_idx_t     cpu_idx;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic [7:0]    cpu_q;
  logic [7:0]    fetch_q;

  wave_ram_array u_array (
    .clk        (clk),
    .we         (wr_en),
    .waddr      (cpu_idx),
    .wdata      (bus.d_in),
    .cpu_addr   (cpu_idx),
    .cpu_q      (cpu_q),
    .fetch_addr (bus.wave_a),
    .fetch_q    (fetch_q)
  );

  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    hit         = is_wave_hit(bus.a);
    // A fetch in this very cycle already opens the window.
    window_open = bus.wave_fetch || (win_cnt_q != '0);
    access_ok   = !bus.ch3_active || window_open;
    cpu_idx     = bus.ch3_active ? bus.wave_a : bus.a[3:0];
    wr_en       = hit && bus.cpu_wr && access_ok && !apu_reset;
    rd_data     = access_ok ? cpu_q : OPEN_BUS;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (apu_reset) begin
      d_out_q   <= '0;
      d_oe_q    <= 1'b0;
      latch_q   <= '0;
      win_cnt_q <= '0;
    end else begin
      d_oe_q <= hit && bus.cpu_rd;
      if (hit && bus.cpu_rd) d_out_q <= rd_data;
      if (bus.wave_fetch)    latch_q <= fetch_q;

      // Channel 3 stopping closes the window immediately.
      if (!bus.ch3_active)     win_cnt_q <= '0;
      else if (bus.wave_fetch) win_cnt_q <= CW'(ACCESS_WINDOW);
      else if (win_cnt_q != '0) win_cnt_q <= win_cnt_q - CW'(1);
    end
  end

  assign bus.d_out       = d_out_q;
  assign bus.d_oe        = d_oe_q;
  assign bus.wave_play_d = bus.efar_q ? latch_q[3:0] : latch_q[7:4];

endmodule
